// File: rtl/wishbone_master.sv
// Purpose: Wishbone classic-cycle master that turns one request into an incrementing-address burst with retry, error and timeout handling.
// Latency: wb_stb_o rises the cycle after accept; with a zero-wait slave it runs one beat per cycle, and done_o follows the last ack by one cycle.
// Backpressure: ready_o is high only in IDLE. Slave wait states stall the current beat, and rty drops stb for one cycle before the beat is re-issued.
module wishbone_master #(
    parameter int TAGSIZE     = 2,
    parameter int MAX_BEATS_W = 3,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [31:0]            addr_i,
    input  logic                   we_i,
    input  logic [3:0]             sel_i,
    input  logic [MAX_BEATS_W-1:0] len_i,
    input  logic [TAGSIZE-1:0]     tag_i,
    input  logic [31:0]            data_i,
    output logic                   wdata_ack_o,
    output logic [31:0]            data_o,
    output logic                   rvalid_o,
    output logic                   done_o,
    output logic                   err_o,
    input  logic [31:0]            wb_dat_i,
    input  logic [TAGSIZE-1:0]     wb_tgd_i,
    input  logic                   wb_ack_i,
    input  logic                   wb_err_i,
    input  logic                   wb_rty_i,
    output logic [31:0]            wb_dat_o,
    output logic [TAGSIZE-1:0]     wb_tgd_o,
    output logic [31:0]            wb_adr_o,
    output logic [TAGSIZE-1:0]     wb_tga_o,
    output logic [TAGSIZE-1:0]     wb_tgc_o,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [3:0]             wb_sel_o
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [31:0]            r_adr;
    logic                   r_we;
    logic [3:0]             r_sel;
    logic [MAX_BEATS_W-1:0] r_len;
    logic [MAX_BEATS_W-1:0] r_beat;
    logic [TAGSIZE-1:0]     r_tag;
    logic [RW-1:0]          r_retry;
    logic [TW-1:0]          r_tmo;
    logic                   r_err;
    logic                   r_rvalid;
    logic [31:0]            r_rdata;

    logic w_accept;
    logic w_beat_ack;
    logic w_retry_inc;
    logic w_tmo_inc;
    logic w_set_err;

    // Response tag and the two ignored address bits have no consumer in this master.
    logic w_unused;
    assign w_unused = ^{wb_tgd_i, addr_i[1:0]};

    // Next-state decode; within BUS the slave responses are ranked err > ack > rty > timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_beat_ack  = 1'b0;
        w_retry_inc = 1'b0;
        w_tmo_inc   = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = BUS;
                end
            end
            BUS: begin
                if (wb_err_i) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = DONE;
                end else if (wb_ack_i) begin
                    w_beat_ack = 1'b1;
                    if (r_beat == r_len) begin
                        w_state_nxt = DONE;
                    end
                end else if (wb_rty_i) begin
                    if (r_retry == RW'(MAX_RETRY)) begin
                        w_set_err   = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_retry_inc = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            WAIT:    w_state_nxt = BUS;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, request capture, beat/retry/timeout counters and registered read data.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state  <= IDLE;
            r_adr    <= '0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_len    <= '0;
            r_beat   <= '0;
            r_tag    <= '0;
            r_retry  <= '0;
            r_tmo    <= '0;
            r_err    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rvalid <= 1'b0;
            if (w_accept) begin
                r_adr   <= {addr_i[31:2], 2'b00};
                r_we    <= we_i;
                r_sel   <= sel_i;
                r_len   <= len_i;
                r_tag   <= tag_i;
                r_beat  <= '0;
                r_retry <= '0;
                r_tmo   <= '0;
                r_err   <= 1'b0;
            end
            if (w_beat_ack) begin
                // Address wraps modulo 2^32 by plain overflow.
                r_adr   <= r_adr + 32'd4;
                r_beat  <= r_beat + MAX_BEATS_W'(1);
                r_retry <= '0;
                r_tmo   <= '0;
                if (!r_we) begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= wb_dat_i;
                end
            end
            if (w_retry_inc) begin
                r_retry <= r_retry + RW'(1);
                r_tmo   <= '0;
            end
            if (w_tmo_inc) begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ready_o     = (r_state == IDLE);
    assign wb_cyc_o    = (r_state == BUS) || (r_state == WAIT);
    assign wb_stb_o    = (r_state == BUS);
    assign wb_adr_o    = r_adr;
    assign wb_we_o     = r_we;
    assign wb_sel_o    = r_sel;
    assign wb_tga_o    = r_tag;
    assign wb_tgc_o    = r_tag;
    assign wb_tgd_o    = r_tag;
    // Write data passes straight through so the caller can advance it on wdata_ack_o.
    assign wb_dat_o    = (r_state == BUS) ? data_i : 32'd0;
    assign wdata_ack_o = (r_state == BUS) && r_we && wb_ack_i && !wb_err_i;
    assign rvalid_o    = r_rvalid;
    assign data_o      = r_rdata;
    assign done_o      = (r_state == DONE);
    assign err_o       = (r_state == DONE) && r_err;

endmodule

// File: tb/tb_wishbone_master.sv
// Purpose: directed self-checking bench for wishbone_master; the bench plays the slave.
// Latency: inputs change on the falling edge, and outputs are checked before the next rising edge.
// Backpressure: slave wait states, retries, errors and timeouts are driven step by step.
module tb_wishbone_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [2:0]  len_i;
    logic [1:0]  tag_i;
    logic [31:0] data_i;
    logic        wdata_ack_o;
    logic [31:0] data_o;
    logic        rvalid_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] wb_dat_i;
    logic [1:0]  wb_tgd_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;
    logic [31:0] wb_dat_o;
    logic [1:0]  wb_tgd_o;
    logic [31:0] wb_adr_o;
    logic [1:0]  wb_tga_o;
    logic [1:0]  wb_tgc_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;

    int n_chk  = 0;
    int n_pass = 0;
    int n_stb  = 0;

    wishbone_master #(
        .TAGSIZE(2), .MAX_BEATS_W(3), .MAX_RETRY(3), .TIMEOUT(255)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .addr_i(addr_i), .we_i(we_i), .sel_i(sel_i), .len_i(len_i), .tag_i(tag_i),
        .data_i(data_i), .wdata_ack_o(wdata_ack_o), .data_o(data_o),
        .rvalid_o(rvalid_o), .done_o(done_o), .err_o(err_o),
        .wb_dat_i(wb_dat_i), .wb_tgd_i(wb_tgd_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_dat_o(wb_dat_o),
        .wb_tgd_o(wb_tgd_o), .wb_adr_o(wb_adr_o), .wb_tga_o(wb_tga_o),
        .wb_tgc_o(wb_tgc_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic request(input logic [31:0] a, input logic w, input logic [2:0] l,
                           input logic [31:0] d);
        valid_i = 1'b1;
        addr_i  = a;
        we_i    = w;
        sel_i   = 4'hF;
        len_i   = l;
        tag_i   = 2'b10;
        data_i  = d;
        tick();
        valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; valid_i = 1'b0; addr_i = '0; we_i = 1'b0; sel_i = '0;
        len_i = '0; tag_i = '0; data_i = '0; wb_dat_i = '0; wb_tgd_i = '0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        @(negedge clk_i);
        tick();
        tick();
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        rst_i = 1'b1;
        tick();

        // Single write with zero-wait ack.
        request(32'h0000_1000, 1'b1, 3'd0, 32'hDEAD_BEEF);
        check("sw_stb", 32'(wb_stb_o), 32'd1);
        check("sw_cyc", 32'(wb_cyc_o), 32'd1);
        check("sw_adr", wb_adr_o, 32'h0000_1000);
        check("sw_we", 32'(wb_we_o), 32'd1);
        check("sw_dat", wb_dat_o, 32'hDEAD_BEEF);
        check("sw_sel", 32'(wb_sel_o), 32'hF);
        check("sw_tga", 32'(wb_tga_o), 32'h2);
        check("sw_tgc", 32'(wb_tgc_o), 32'h2);
        check("sw_tgd", 32'(wb_tgd_o), 32'h2);
        check("sw_ready_busy", 32'(ready_o), 32'd0);
        wb_ack_i = 1'b1;
        #1;
        check("sw_wdata_ack", 32'(wdata_ack_o), 32'd1);
        tick();
        wb_ack_i = 1'b0;
        check("sw_done", 32'(done_o), 32'd1);
        check("sw_err", 32'(err_o), 32'd0);
        check("sw_cyc_drop", 32'(wb_cyc_o), 32'd0);
        check("sw_ready_done", 32'(ready_o), 32'd0);
        tick();
        check("sw_ready_after", 32'(ready_o), 32'd1);
        check("sw_done_clear", 32'(done_o), 32'd0);

        // Four-beat read burst, one wait state per beat.
        request(32'h0000_2000, 1'b0, 3'd3, 32'd0);
        for (int b = 0; b < 4; b++) begin
            check("rb_stb", 32'(wb_stb_o), 32'd1);
            check("rb_cyc", 32'(wb_cyc_o), 32'd1);
            check("rb_adr", wb_adr_o, 32'h0000_2000 + 32'(4 * b));
            check("rb_we", 32'(wb_we_o), 32'd0);
            if (b > 0) begin
                check("rb_rvalid", 32'(rvalid_o), 32'd1);
                check("rb_data", data_o, 32'h0000_00A0 + 32'(b - 1));
            end
            tick();
            check("rb_cyc_ack", 32'(wb_cyc_o), 32'd1);
            check("rb_rvalid_idle", 32'(rvalid_o), 32'd0);
            wb_ack_i = 1'b1;
            wb_dat_i = 32'h0000_00A0 + 32'(b);
            tick();
            wb_ack_i = 1'b0;
        end
        check("rb_rvalid_last", 32'(rvalid_o), 32'd1);
        check("rb_data_last", data_o, 32'h0000_00A3);
        check("rb_done", 32'(done_o), 32'd1);
        check("rb_err", 32'(err_o), 32'd0);
        tick();
        check("rb_ready", 32'(ready_o), 32'd1);

        // One retry, then ack.
        request(32'h0000_3000, 1'b1, 3'd0, 32'h1234_5678);
        wb_rty_i = 1'b1;
        tick();
        wb_rty_i = 1'b0;
        check("ry_wait_stb", 32'(wb_stb_o), 32'd0);
        check("ry_wait_cyc", 32'(wb_cyc_o), 32'd1);
        tick();
        check("ry_reissue_stb", 32'(wb_stb_o), 32'd1);
        check("ry_reissue_adr", wb_adr_o, 32'h0000_3000);
        wb_ack_i = 1'b1;
        #1;
        check("ry_wdata_ack", 32'(wdata_ack_o), 32'd1);
        tick();
        wb_ack_i = 1'b0;
        check("ry_done", 32'(done_o), 32'd1);
        check("ry_err", 32'(err_o), 32'd0);
        tick();

        // Four retries exceed the limit of three.
        request(32'h0000_3100, 1'b1, 3'd0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("rl_stb", 32'(wb_stb_o), 32'd1);
            wb_rty_i = 1'b1;
            tick();
            wb_rty_i = 1'b0;
            if (i < 3) begin
                check("rl_wait_stb", 32'(wb_stb_o), 32'd0);
                check("rl_wait_cyc", 32'(wb_cyc_o), 32'd1);
                tick();
            end
        end
        check("rl_done", 32'(done_o), 32'd1);
        check("rl_err", 32'(err_o), 32'd1);
        tick();
        check("rl_ready", 32'(ready_o), 32'd1);

        // err on beat 1 of a four-beat write.
        request(32'h0000_4000, 1'b1, 3'd3, 32'h1111_1111);
        wb_ack_i = 1'b1;
        #1;
        check("er_ack0", 32'(wdata_ack_o), 32'd1);
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b1;
        #1;
        check("er_adr1", wb_adr_o, 32'h0000_4004);
        check("er_no_ack1", 32'(wdata_ack_o), 32'd0);
        tick();
        wb_err_i = 1'b0;
        check("er_done", 32'(done_o), 32'd1);
        check("er_err", 32'(err_o), 32'd1);
        check("er_cyc", 32'(wb_cyc_o), 32'd0);
        tick();

        // Timeout: slave never answers.
        request(32'h0000_5000, 1'b0, 3'd0, 32'h0);
        n_stb = 0;
        while (wb_stb_o && n_stb < 400) begin
            n_stb++;
            tick();
        end
        check("to_stb_cycles", 32'(n_stb), 32'd255);
        check("to_done", 32'(done_o), 32'd1);
        check("to_err", 32'(err_o), 32'd1);
        tick();
        check("to_ready", 32'(ready_o), 32'd1);

        // ack and err together count as err.
        request(32'h0000_6000, 1'b0, 3'd1, 32'h0);
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        wb_dat_i = 32'hBAD0_BAD0;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        check("ae_done", 32'(done_o), 32'd1);
        check("ae_err", 32'(err_o), 32'd1);
        check("ae_rvalid", 32'(rvalid_o), 32'd0);
        tick();

        // Reset mid-burst.
        request(32'h0000_7000, 1'b1, 3'd3, 32'h7777_7777);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("mr_busy_stb", 32'(wb_stb_o), 32'd1);
        rst_i = 1'b0;
        tick();
        check("mr_ready", 32'(ready_o), 32'd1);
        check("mr_cyc", 32'(wb_cyc_o), 32'd0);
        check("mr_stb", 32'(wb_stb_o), 32'd0);
        check("mr_done", 32'(done_o), 32'd0);
        check("mr_adr", wb_adr_o, 32'd0);
        check("mr_we", 32'(wb_we_o), 32'd0);
        rst_i = 1'b1;
        tick();
        check("mr_no_done", 32'(done_o), 32'd0);

        // Address wraps past 0xFFFFFFFC.
        request(32'hFFFF_FFFC, 1'b0, 3'd1, 32'h0);
        check("wr_adr0", wb_adr_o, 32'hFFFF_FFFC);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0000_0055;
        tick();
        check("wr_adr1", wb_adr_o, 32'h0000_0000);
        check("wr_rvalid0", 32'(rvalid_o), 32'd1);
        check("wr_data0", data_o, 32'h0000_0055);
        wb_dat_i = 32'h0000_0066;
        tick();
        wb_ack_i = 1'b0;
        check("wr_done", 32'(done_o), 32'd1);
        check("wr_err", 32'(err_o), 32'd0);
        check("wr_data1", data_o, 32'h0000_0066);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
